mem_access_controller: RTL and testbench
========================================

MEM_ACCESS_CONTROLLER -- requirements
Module: mem_access_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, ack wait limit in cycles; used only with MEM_ACCESS_TIMEOUT_EN.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset; asynchronous, active-low.
REQ-004 i_mem_read  input  1  MEM-stage load request.
REQ-005 i_mem_write  input  1  MEM-stage store request.
REQ-006 i_load_store_type  input  3  000 B, 001 H, 011 W, 100 BU, 101 HU, 111 WU; others treated as W.
REQ-007 i_addr  input  32  byte address.
REQ-008 i_wdata  input  32  store data, right-justified.
REQ-009 o_mem_req  output  1  memory request, held until ack.
REQ-010 o_mem_we  output  1  write strobe qualifying o_mem_req.
REQ-011 o_mem_addr  output  32  {addr[31:2],2'b00}.
REQ-012 o_mem_be  output  4  byte enables.
REQ-013 o_mem_wdata  output  32  lane-replicated store data.
REQ-014 i_mem_ack  input  1  memory completion, one cycle.
REQ-015 i_mem_rdata  input  32  read word, valid with i_mem_ack.
REQ-016 o_stall  output  1  hold pipeline.
REQ-017 o_valid  output  1  one-cycle pulse: access complete.
REQ-018 o_load  output  32  aligned, extended load result.
REQ-019 o_misaligned  output  1  one-cycle pulse: access rejected.

Function
REQ-020 FSM states SHALL be IDLE, BUSY, DONE, ERR.
REQ-021 IDLE with read or write and aligned address SHALL register type/addr/wdata, go BUSY; o_stall high combinationally in that cycle.
REQ-022 Read and write both high SHALL be treated as write.
REQ-023 Misalignment: H/HU with addr[0]=1, W/WU with addr[1:0]!=0; SHALL go ERR, no o_mem_req issued.
REQ-024 BUSY SHALL drive o_mem_req=1, o_stall=1, stable addr/be/wdata/we until i_mem_ack; ack -> DONE, rdata captured.
REQ-025 DONE SHALL last one cycle: o_valid=1, o_stall=0, o_mem_req=0, then IDLE; new request not accepted in DONE.
REQ-026 ERR SHALL last one cycle: o_misaligned=1, o_stall=0, then IDLE.
REQ-027 Minimum latency: request cycle N, ack in N+1, o_valid in N+2; o_stall high N and N+1.
REQ-028 Byte enables: B = 0001<<addr[1:0]; H = 0011<<addr[1:0]; W = 1111; loads use same mask.
REQ-029 Store data: B {4{wdata[7:0]}}, H {2{wdata[15:0]}}, W wdata.
REQ-030 Load: shift rdata right by 8*addr[1:0]; B/H sign-extend, BU/HU zero-extend, W/WU unmodified.
REQ-031 o_load SHALL hold its value outside DONE; stores do not update it.
REQ-032 i_mem_ack outside BUSY SHALL be ignored.

Reset
REQ-033 i_rst_n low SHALL immediately force IDLE and all outputs 0 (o_load 0), including mid-BUSY with o_mem_req dropped same instant.

Configuration
REQ-034 With MEM_ACCESS_TIMEOUT_EN defined: counter cleared on BUSY entry; after TIMEOUT_CYCLES BUSY cycles without ack SHALL abort to ERR (o_misaligned pulse reused as error); undefined: BUSY waits indefinitely, no counter logic.

Structure
REQ-035 Shared package SHALL hold load/store type codes, FSM state encoding, and the BE/replication constants.
REQ-036 Sub-module load_align_extend (rdata, offset, type -> o_load) SHALL be combinational, instantiated once.

Verification
REQ-037 LB addr 0x103, rdata 0x81000000, ack next cycle -> o_load 0xFFFFFF81, o_valid at N+2.
REQ-038 SH addr 0x202, wdata 0x1234ABCD -> be 1100, wdata 0xABCDABCD, we=1, o_mem_addr 0x200.
REQ-039 LW addr 0x101 -> o_misaligned pulse at N+1, o_mem_req never high.
REQ-040 LHU addr 0x002, ack after 5 cycles, rdata 0x80010000 -> o_stall 6 cycles, o_load 0x00008001.
REQ-041 Reset asserted in BUSY -> o_mem_req/o_stall 0 asynchronously; post-reset stray ack ignored.
REQ-042 MEM_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> ERR pulse after 4 BUSY cycles, then IDLE.

Source files
------------

// File: rtl/mem_access_controller_pkg.sv
// Shared definitions for the MEM-stage access controller: load/store type codes,
// FSM state encoding, byte-enable masks and lane helpers.
package mem_access_controller_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b011;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;
  localparam logic [2:0] LS_WU = 3'b111;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Unlisted type codes fall through to word accesses.
  function automatic size_e size_of(input logic [2:0] ls_type);
    case (ls_type)
      LS_B, LS_BU: return SZ_BYTE;
      LS_H, LS_HU: return SZ_HALF;
      LS_W, LS_WU: return SZ_WORD;
      default:     return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_unsigned(input logic [2:0] ls_type);
    return (ls_type == LS_BU) || (ls_type == LS_HU);
  endfunction

  function automatic logic access_misaligned(input logic [2:0] ls_type,
                                             input logic [1:0] offset);
    case (size_of(ls_type))
      SZ_HALF: return offset[0];
      SZ_WORD: return |offset;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] ls_type,
                                              input logic [1:0] offset);
    case (size_of(ls_type))
      SZ_BYTE: return BE_BYTE << offset;
      SZ_HALF: return BE_HALF << offset;
      default: return BE_WORD;
    endcase
  endfunction

  function automatic logic [31:0] replicate_wdata(input logic [2:0] ls_type,
                                                  input logic [31:0] wdata);
    case (size_of(ls_type))
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_controller_if.sv
// Memory-side bus of the access controller; master = controller, slave = memory.
interface mem_access_controller_if;

  // Handshake: the master raises mem_req with mem_we/mem_addr/mem_be/mem_wdata
  // and holds all of them stable until the slave returns a single-cycle
  // mem_ack (with mem_rdata valid in that same cycle); mem_ack while mem_req
  // is low carries no meaning and is ignored.
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_be,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_be,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/mem_access_controller_load_align_extend.sv
// Combinational load alignment: shifts the returned word down to the addressed
// lane and sign/zero extends according to the load type.
module load_align_extend
  import mem_access_controller_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  ls_type,
  output logic [31:0] o_load
);

  logic [31:0] shifted;
  logic        fill;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    fill    = 1'b0;
    o_load  = shifted;
    case (size_of(ls_type))
      SZ_BYTE: begin
        fill   = ~is_unsigned(ls_type) & shifted[7];
        o_load = {{24{fill}}, shifted[7:0]};
      end
      SZ_HALF: begin
        fill   = ~is_unsigned(ls_type) & shifted[15];
        o_load = {{16{fill}}, shifted[15:0]};
      end
      default: o_load = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_controller.sv
// MEM-stage load/store controller: IDLE/BUSY/DONE/ERR handshake with memory,
// lane steering and load extension. Optional ack timeout: MEM_ACCESS_TIMEOUT_EN.
module mem_access_controller
  import mem_access_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_mem_read,
  input  logic                           i_mem_write,
  input  logic [2:0]                     i_load_store_type,
  input  logic [31:0]                    i_addr,
  input  logic [31:0]                    i_wdata,
  mem_access_controller_if.master        mem,
  output logic                           o_stall,
  output logic                           o_valid,
  output logic [31:0]                    o_load,
  output logic                           o_misaligned,
  output state_e                         o_dbg_state
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e      state_q, state_d;
  logic        req_valid;
  logic        req_misaligned;
  logic        accept;
  logic        ack_in_busy;
  logic        timeout_hit;

  logic        we_q;
  logic [2:0]  type_q;
  logic [1:0]  off_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] load_q;
  logic [31:0] load_aligned;

  logic        stall_c, valid_c, misaligned_c, req_c;

  // A write wins when both strobes are high, so only the type decides alignment.
  assign req_valid      = i_mem_read | i_mem_write;
  assign req_misaligned = access_misaligned(i_load_store_type, i_addr[1:0]);
  assign accept         = (state_q == ST_IDLE) && req_valid && !req_misaligned;
  assign ack_in_busy    = (state_q == ST_BUSY) && mem.mem_ack;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q;

  // Held at zero outside BUSY, so it restarts on every BUSY entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt_q <= '0;
    end else if (state_q != ST_BUSY) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    stall_c      = 1'b0;
    valid_c      = 1'b0;
    misaligned_c = 1'b0;
    req_c        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Stall on any request so the pipeline still holds the instruction
        // when the rejection pulse arrives.
        if (req_valid) begin
          stall_c = 1'b1;
          state_d = req_misaligned ? ST_ERR : ST_BUSY;
        end
      end
      ST_BUSY: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (mem.mem_ack) begin
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          state_d = ST_ERR;
        end
      end
      ST_DONE: begin
        valid_c = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        misaligned_c = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset also masks the request-driven stall path so every output is 0 at once.
  assign o_stall       = stall_c & i_rst_n;
  assign o_valid       = valid_c & i_rst_n;
  assign o_misaligned  = misaligned_c & i_rst_n;
  assign mem.mem_req   = req_c & i_rst_n;
  assign mem.mem_we    = req_c & we_q & i_rst_n;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;
  assign o_load        = load_q;
  assign o_dbg_state   = state_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      we_q    <= 1'b0;
      type_q  <= 3'b000;
      off_q   <= 2'b00;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= i_mem_write;
      type_q  <= i_load_store_type;
      off_q   <= i_addr[1:0];
      addr_q  <= {i_addr[31:2], 2'b00};
      be_q    <= byte_enables(i_load_store_type, i_addr[1:0]);
      wdata_q <= replicate_wdata(i_load_store_type, i_wdata);
    end
  end

  load_align_extend u_load_align_extend (
    .rdata   (mem.mem_rdata),
    .offset  (off_q),
    .ls_type (type_q),
    .o_load  (load_aligned)
  );

  // Only a completing load updates the result; stores leave it untouched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      load_q <= '0;
    end else if (ack_in_busy && !we_q) begin
      load_q <= load_aligned;
    end
  end

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed + randomized bench for mem_access_controller with a byte-lane reference
// model; the timeout scenario runs when MEM_ACCESS_TIMEOUT_EN is defined.
module tb_mem_access_controller;
  import mem_access_controller_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  ls_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        o_stall;
  logic        o_valid;
  logic [31:0] o_load;
  logic        o_misaligned;
  state_e      dbg_state;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_load;

  mem_access_controller_if bus ();

  mem_access_controller #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_mem_read        (mem_read),
    .i_mem_write       (mem_write),
    .i_load_store_type (ls_type),
    .i_addr            (addr),
    .i_wdata           (wdata),
    .mem               (bus.master),
    .o_stall           (o_stall),
    .o_valid           (o_valid),
    .o_load            (o_load),
    .o_misaligned      (o_misaligned),
    .o_dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] t);
    case (t)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic model_misaligned(input logic [2:0] t, input logic [31:0] a);
    return (int'(a[1:0]) % nbytes(t)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] t, input logic [31:0] a);
    int m;
    m = ((1 << nbytes(t)) - 1) << int'(a[1:0]);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] t, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = nbytes(t);
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] t, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] v;
    logic [31:0] mask;
    int n;
    n = nbytes(t);
    v = rd >> (8 * int'(a[1:0]));
    if (n < 4) begin
      mask = (32'h1 << (8 * n)) - 32'h1;
      v = v & mask;
      if (!t[2] && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic do_access(input logic rd, input logic wr, input logic [2:0] t,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd_word, input int dly);
    logic bad;
    logic [3:0] e_be;
    logic [31:0] e_wd;
    bad  = model_misaligned(t, a);
    e_be = model_be(t, a);
    e_wd = model_wdata(t, wd);
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; ls_type = t; addr = a; wdata = wd;
    @(negedge clk);
    check("req_cycle_stall", 32'(o_stall), 32'd1);
    check("req_cycle_mem_req", 32'(bus.mem_req), 32'd0);
    if (bad) begin
      @(posedge clk); #1; idle_inputs();
      @(negedge clk);
      check("err_pulse", 32'(o_misaligned), 32'd1);
      check("err_mem_req", 32'(bus.mem_req), 32'd0);
      check("err_stall", 32'(o_stall), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("err_one_cycle", 32'(o_misaligned), 32'd0);
      check("err_no_valid", 32'(o_valid), 32'd0);
      check("err_load_hold", o_load, last_load);
      return;
    end
    if (!wr) exp_q.push_back(model_load(t, a, rd_word));
    for (int c = 0; c <= dly; c++) begin
      @(posedge clk); #1;
      if (c == dly) begin
        bus.mem_ack = 1'b1; bus.mem_rdata = rd_word;
      end else begin
        bus.mem_rdata = $urandom;
      end
      @(negedge clk);
      check("busy_mem_req", 32'(bus.mem_req), 32'd1);
      check("busy_stall", 32'(o_stall), 32'd1);
      check("busy_we", 32'(bus.mem_we), 32'(wr));
      check("busy_addr", bus.mem_addr, {a[31:2], 2'b00});
      check("busy_be", 32'(bus.mem_be), 32'(e_be));
      check("busy_valid", 32'(o_valid), 32'd0);
      if (wr) check("busy_wdata", bus.mem_wdata, e_wd);
    end
    @(posedge clk); #1;
    bus.mem_ack = 1'b0; bus.mem_rdata = $urandom; idle_inputs();
    @(negedge clk);
    check("done_valid", 32'(o_valid), 32'd1);
    check("done_stall", 32'(o_stall), 32'd0);
    check("done_mem_req", 32'(bus.mem_req), 32'd0);
    check("done_misaligned", 32'(o_misaligned), 32'd0);
    if (!wr) last_load = exp_q.pop_front();
    check("done_load", o_load, last_load);
    @(posedge clk); #1;
    @(negedge clk);
    check("after_done_valid", 32'(o_valid), 32'd0);
    check("load_hold", o_load, last_load);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  t;
    logic [31:0] a;
    logic        r_w;
    rst_n = 1'b0;
    idle_inputs();
    ls_type = 3'b000; addr = '0; wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    last_load = '0;
    #12;
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_stall", 32'(o_stall), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_misaligned", 32'(o_misaligned), 32'd0);
    check("rst_load", o_load, 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_be", 32'(bus.mem_be), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // LB sign-extended from the top lane, ack in the first BUSY cycle
    do_access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h8100_0000, 0);
    // SH to upper half
    do_access(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 0);
    // LW misaligned
    do_access(1'b1, 1'b0, 3'b011, 32'h0000_0101, 32'h0, 32'h0, 0);
    // LHU with ack on the fifth BUSY cycle: six stall cycles
    do_access(1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0, 32'h8001_0000, 4);
    // read+write together behaves as a write
    do_access(1'b1, 1'b1, 3'b011, 32'h0000_0300, 32'hCAFE_F00D, 32'h1111_1111, 1);
    // unlisted type code acts as a word access
    do_access(1'b1, 1'b0, 3'b110, 32'h0000_0010, 32'h0, 32'hF0E1_D2C3, 2);
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_0012, 32'h0, 32'h0, 0);

    // stray ack in IDLE
    @(posedge clk); #1; bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("stray_ack_req", 32'(bus.mem_req), 32'd0);
    @(posedge clk); #1; bus.mem_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_valid", 32'(o_valid), 32'd0);
    check("stray_ack_load", o_load, last_load);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      t = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = a[1:0] & 2'(~(nbytes(t) - 1));
      r_w = 1'($urandom_range(0, 1));
      do_access(r_w | 1'($urandom_range(0, 1)) & ~r_w ? 1'b1 : 1'b0, ~r_w,
                t, a, $urandom, $urandom, $urandom_range(0, 3));
    end

    // asynchronous reset in the middle of BUSY
    @(posedge clk); #1;
    mem_read = 1'b1; ls_type = 3'b011; addr = 32'h0000_0800;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_busy_req", 32'(bus.mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("async_rst_stall", 32'(o_stall), 32'd0);
    check("async_rst_load", o_load, 32'd0);
    last_load = '0;
    idle_inputs();
    @(posedge clk); #1; rst_n = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h7777_7777;
    @(negedge clk);
    check("post_rst_ack_req", 32'(bus.mem_req), 32'd0);
    @(posedge clk); #1; bus.mem_ack = 1'b0;
    @(negedge clk);
    check("post_rst_ack_valid", 32'(o_valid), 32'd0);
    check("post_rst_ack_load", o_load, 32'd0);

    // clean access after reset
    do_access(1'b1, 1'b0, 3'b001, 32'h0000_0406, 32'h0, 32'hFFFE_0000, 1);

`ifdef MEM_ACCESS_TIMEOUT_EN
    @(posedge clk); #1;
    mem_read = 1'b1; ls_type = 3'b011; addr = 32'h0000_0400;
    @(negedge clk);
    check("to_req_stall", 32'(o_stall), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("to_busy_req", 32'(bus.mem_req), 32'd1);
      check("to_busy_err", 32'(o_misaligned), 32'd0);
    end
    @(posedge clk); #1; idle_inputs();
    @(negedge clk);
    check("to_err_pulse", 32'(o_misaligned), 32'd1);
    check("to_err_req", 32'(bus.mem_req), 32'd0);
    check("to_err_valid", 32'(o_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("to_back_idle", 32'(o_misaligned), 32'd0);
    check("to_load_hold", o_load, last_load);
`endif

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
